updown_seq_ctrl: RTL and testbench

//  Command-driven sequencer for the WIDTH-bit up/down counter datapath.

---
 rtl/updown_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_updown_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_seq_ctrl.sv
// Command sequencer for an external up/down counter: GOTO, BOUNCE and CLEAR
// commands arrive over a valid/ready handshake and steer the counter's enable, direction and clear.
module updown_seq_ctrl #(
   parameter int WIDTH     = 3,
   parameter int DWELL_CYC = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic [3:0]       cmd_passes,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             cnt_clr,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC + 1) : 1;

   localparam logic [1:0] MODE_GOTO   = 2'b00;
   localparam logic [1:0] MODE_BOUNCE = 2'b01;
   localparam logic [1:0] MODE_CLEAR  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_RUN   = 3'd2,
      S_DWELL = 3'd3,
      S_DONE  = 3'd4,
      S_FAIL  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [3:0]       passes_q, passes_d;
   logic [3:0]       pass_cnt_q, pass_cnt_d;
   logic             leg_up_q, leg_up_d;
   logic [DW-1:0]    dwell_cnt_q, dwell_cnt_d;
   logic             cnt_up_q;

   logic [WIDTH-1:0] goal;
   logic             at_goal;

   // The counter is steered combinationally so that abort and arrival at the goal
   // take effect in the same cycle; direction is held while the counter is idle.
   always_comb begin
      goal      = leg_up_q ? target_q : '0;
      at_goal   = (cnt_q == goal);
      cnt_en    = (state_q == S_RUN) && !at_goal && !abort;
      cnt_up    = cnt_en ? (cnt_q < goal) : cnt_up_q;
      cnt_clr   = (state_q == S_CLEAR) && !abort;
      busy      = (state_q != S_IDLE);
      cmd_ready = (state_q == S_IDLE);
      done      = (state_q == S_DONE);
      err       = (state_q == S_FAIL);
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      target_d    = target_q;
      passes_d    = passes_q;
      pass_cnt_d  = pass_cnt_q;
      leg_up_d    = leg_up_q;
      dwell_cnt_d = dwell_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               mode_d     = cmd_mode;
               target_d   = cmd_target;
               passes_d   = (cmd_passes == 4'd0) ? 4'd1 : cmd_passes;
               pass_cnt_d = 4'd0;
               leg_up_d   = 1'b1;
               case (cmd_mode)
                  MODE_GOTO:   state_d = S_RUN;
                  MODE_CLEAR:  state_d = S_CLEAR;
                  MODE_BOUNCE: state_d = (cmd_target != '0) ? S_CLEAR : S_FAIL;
                  default:     state_d = S_FAIL;
               endcase
            end
         end

         S_CLEAR: begin
            if (abort) begin
               state_d = S_FAIL;
            end else if (mode_q == MODE_BOUNCE) begin
               state_d  = S_RUN;
               leg_up_d = 1'b1;
            end else begin
               state_d = S_DONE;
            end
         end

         // A bounce pass is complete only when the down leg lands on zero.
         S_RUN: begin
            if (abort) begin
               state_d = S_FAIL;
            end else if (at_goal) begin
               if (mode_q != MODE_BOUNCE) begin
                  state_d = S_DONE;
               end else if (leg_up_q) begin
                  state_d     = S_DWELL;
                  dwell_cnt_d = '0;
               end else if ((pass_cnt_q + 4'd1) == passes_q) begin
                  state_d = S_DONE;
               end else begin
                  pass_cnt_d  = pass_cnt_q + 4'd1;
                  state_d     = S_DWELL;
                  dwell_cnt_d = '0;
               end
            end
         end

         S_DWELL: begin
            if (abort) begin
               state_d = S_FAIL;
            end else if (dwell_cnt_q == DW'(DWELL_CYC - 1)) begin
               state_d  = S_RUN;
               leg_up_d = ~leg_up_q;
            end else begin
               dwell_cnt_d = dwell_cnt_q + DW'(1);
            end
         end

         S_DONE:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         mode_q      <= MODE_GOTO;
         target_q    <= '0;
         passes_q    <= 4'd0;
         pass_cnt_q  <= 4'd0;
         leg_up_q    <= 1'b1;
         dwell_cnt_q <= '0;
         cnt_up_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         target_q    <= target_d;
         passes_q    <= passes_d;
         pass_cnt_q  <= pass_cnt_d;
         leg_up_q    <= leg_up_d;
         dwell_cnt_q <= dwell_cnt_d;
         cnt_up_q    <= cnt_up;
      end
   end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Self-checking bench for updown_seq_ctrl: a behavioural 3-bit up/down counter
// closes the loop, a vector table covers whole commands, hand sequences cover reset and abort.
module tb_updown_seq_ctrl;

   logic       clk;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_mode;
   logic [2:0] cmd_target;
   logic [3:0] cmd_passes;
   logic       abort;
   logic [2:0] cnt_q;
   logic       cnt_en;
   logic       cnt_up;
   logic       cnt_clr;
   logic       busy;
   logic       done;
   logic       err;

   logic       load;
   logic [2:0] load_val;

   int checks = 0;
   int errors = 0;

   updown_seq_ctrl #(.WIDTH(3), .DWELL_CYC(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_target (cmd_target),
      .cmd_passes (cmd_passes),
      .abort      (abort),
      .cnt_q      (cnt_q),
      .cnt_en     (cnt_en),
      .cnt_up     (cnt_up),
      .cnt_clr    (cnt_clr),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter datapath model; the bench preload lets each command start from a chosen value.
   always @(posedge clk) begin
      if (load)         cnt_q <= load_val;
      else if (cnt_clr) cnt_q <= 3'd0;
      else if (cnt_en)  cnt_q <= cnt_up ? cnt_q + 3'd1 : cnt_q - 3'd1;
   end

   typedef struct {
      logic [1:0] mode;
      int         start_q;
      int         target;
      int         passes;
      bit         abort_acc;
      int         exp_q;
      int         exp_up;
      int         exp_dn;
      int         exp_clr;
      int         exp_done;
      int         exp_err;
   } vec_t;

   vec_t vecs[11];

   int obs_up, obs_dn, obs_clr, obs_done_lat, obs_err_lat, obs_done_cnt, obs_err_cnt, obs_q;
   bit obs_fin;
   int qtrace[64];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Preload the counter, present one command, then observe until the controller is idle again.
   task automatic applyStimulus(input logic [1:0] mode, input int start_q, input int target,
                                input int passes, input bit abort_acc);
      load     = 1'b1;
      load_val = 3'(start_q);
      tick();
      load       = 1'b0;
      cmd_mode   = mode;
      cmd_target = 3'(target);
      cmd_passes = 4'(passes);
      cmd_valid  = 1'b1;
      abort      = abort_acc;
      #1;
      checkOutput("ready_before_accept", 32'(cmd_ready), 32'd1);
      obs_up = 0; obs_dn = 0; obs_clr = 0; obs_done_lat = 0; obs_err_lat = 0;
      obs_done_cnt = 0; obs_err_cnt = 0; obs_q = -1; obs_fin = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         cmd_valid = 1'b0;
         abort     = 1'b0;
         #1;
         qtrace[k] = int'(cnt_q);
         if (cnt_en) begin
            if (cnt_up) obs_up++;
            else        obs_dn++;
         end
         if (cnt_clr) obs_clr++;
         if (done) begin
            obs_done_cnt++;
            if (obs_done_lat == 0) obs_done_lat = k;
         end
         if (err) begin
            obs_err_cnt++;
            if (obs_err_lat == 0) obs_err_lat = k;
         end
         if (cmd_ready) begin
            obs_q   = int'(cnt_q);
            obs_fin = 1'b1;
            break;
         end
      end
      checkOutput("cmd_completes_in_bound", 32'(obs_fin), 32'd1);
   endtask

   int exp_tr[24];
   int ready_seen;
   bit found;

   initial begin
      //               mode  sq tg ps ab  q  up dn clr done err
      vecs[0]  = '{2'b00, 2, 5, 1, 1'b0, 5, 3, 0, 0, 5, 0};
      vecs[1]  = '{2'b00, 5, 5, 1, 1'b0, 5, 0, 0, 0, 2, 0};
      vecs[2]  = '{2'b00, 6, 1, 1, 1'b0, 1, 0, 5, 0, 7, 0};
      vecs[3]  = '{2'b00, 0, 7, 1, 1'b0, 7, 7, 0, 0, 9, 0};
      vecs[4]  = '{2'b00, 7, 0, 1, 1'b0, 0, 0, 7, 0, 9, 0};
      vecs[5]  = '{2'b00, 3, 4, 1, 1'b1, 4, 1, 0, 0, 3, 0};
      vecs[6]  = '{2'b10, 6, 0, 1, 1'b0, 0, 0, 0, 1, 2, 0};
      vecs[7]  = '{2'b01, 5, 3, 2, 1'b0, 0, 6, 6, 1, 24, 0};
      vecs[8]  = '{2'b01, 4, 2, 0, 1'b0, 0, 2, 2, 1, 10, 0};
      vecs[9]  = '{2'b01, 4, 0, 1, 1'b0, 4, 0, 0, 0, 0, 1};
      vecs[10] = '{2'b11, 1, 5, 1, 1'b0, 1, 0, 0, 0, 0, 1};

      exp_tr = '{5, 0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 2, 1, 0, 0};

      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_mode   = 2'b00;
      cmd_target = 3'd0;
      cmd_passes = 4'd0;
      abort      = 1'b0;
      load       = 1'b1;
      load_val   = 3'd0;
      tick();
      tick();
      load = 1'b0;
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_busy",      32'(busy),      32'd0);
      checkOutput("rst_cnt_en",    32'(cnt_en),    32'd0);
      checkOutput("rst_cnt_up",    32'(cnt_up),    32'd0);
      checkOutput("rst_cnt_clr",   32'(cnt_clr),   32'd0);
      checkOutput("rst_done",      32'(done),      32'd0);
      checkOutput("rst_err",       32'(err),       32'd0);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].mode, vecs[i].start_q, vecs[i].target, vecs[i].passes, vecs[i].abort_acc);
         checkOutput($sformatf("v%0d_final_q", i),  32'(obs_q),        32'(vecs[i].exp_q));
         checkOutput($sformatf("v%0d_en_up", i),    32'(obs_up),       32'(vecs[i].exp_up));
         checkOutput($sformatf("v%0d_en_down", i),  32'(obs_dn),       32'(vecs[i].exp_dn));
         checkOutput($sformatf("v%0d_clr", i),      32'(obs_clr),      32'(vecs[i].exp_clr));
         checkOutput($sformatf("v%0d_done_lat", i), 32'(obs_done_lat), 32'(vecs[i].exp_done));
         checkOutput($sformatf("v%0d_err_lat", i),  32'(obs_err_lat),  32'(vecs[i].exp_err));
         checkOutput($sformatf("v%0d_pulses", i),   32'(obs_done_cnt + obs_err_cnt), 32'd1);
      end

      // Bounce 3 x 2 from a preload of 5: cycle-by-cycle counter trajectory.
      applyStimulus(2'b01, 5, 3, 2, 1'b0);
      for (int k = 1; k <= 24; k++)
         checkOutput($sformatf("bounce_q_c%0d", k), 32'(qtrace[k]), 32'(exp_tr[k-1]));

      // Reset asserted mid-GOTO 0->7 once the counter reaches 3.
      load = 1'b1; load_val = 3'd0;
      tick();
      load = 1'b0;
      cmd_mode = 2'b00; cmd_target = 3'd7; cmd_passes = 4'd1; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (cnt_q == 3'd3) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("rst_mid_reached_q3", 32'(found), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_mid_cnt_en", 32'(cnt_en), 32'd0);
      checkOutput("rst_mid_cnt_up", 32'(cnt_up), 32'd0);
      checkOutput("rst_mid_busy",   32'(busy),   32'd0);
      checkOutput("rst_mid_done",   32'(done),   32'd0);
      tick();
      tick();
      checkOutput("rst_mid_q_held", 32'(cnt_q), 32'd3);
      reset_n = 1'b1;
      #1;
      checkOutput("rst_mid_ready", 32'(cmd_ready), 32'd1);
      tick();
      checkOutput("rst_mid_q_after", 32'(cnt_q), 32'd3);

      // Abort on the bounce down leg at q=2, with a GOTO 7 held valid throughout.
      load = 1'b1; load_val = 3'd5;
      tick();
      load = 1'b0;
      cmd_mode = 2'b01; cmd_target = 3'd3; cmd_passes = 4'd1; cmd_valid = 1'b1;
      tick();
      cmd_mode = 2'b00; cmd_target = 3'd7;
      ready_seen = 0;
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (cmd_ready) ready_seen++;
         if (cnt_q == 3'd2 && cnt_en && !cnt_up) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("abort_reached_down_q2", 32'(found), 32'd1);
      checkOutput("abort_no_ready_busy", 32'(ready_seen), 32'd0);
      abort = 1'b1;
      #1;
      checkOutput("abort_cnt_en_drop", 32'(cnt_en),  32'd0);
      checkOutput("abort_cnt_clr",     32'(cnt_clr), 32'd0);
      checkOutput("abort_busy",        32'(busy),    32'd1);
      tick();
      abort = 1'b0;
      #1;
      checkOutput("abort_err_pulse", 32'(err),       32'd1);
      checkOutput("abort_q_stays",   32'(cnt_q),     32'd2);
      checkOutput("abort_not_ready", 32'(cmd_ready), 32'd0);
      tick();
      checkOutput("abort_idle_ready", 32'(cmd_ready), 32'd1);
      checkOutput("abort_err_once",   32'(err),       32'd0);
      tick();
      cmd_valid = 1'b0;
      #1;
      checkOutput("held_cmd_busy",  32'(busy),   32'd1);
      checkOutput("held_cmd_en",    32'(cnt_en), 32'd1);
      checkOutput("held_cmd_up",    32'(cnt_up), 32'd1);
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("held_cmd_done", 32'(found), 32'd1);
      checkOutput("held_cmd_q",    32'(cnt_q), 32'd7);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
